control_pad_encoder: RTL and testbench
======================================

Name: control_pad_encoder

Overview:
- Producer of the 12-bit controlPad bus consumed by the object transform/state block, which steps position and angle once per fclk cycle while a pair code is non-zero.
- Samples 12 raw asynchronous push-buttons, synchronises and debounces them, resolves conflicting pairs, and emits one-cycle step pulses with press-and-hold auto-repeat.
- Result: one press gives one step, and a held button gives paced steps, instead of a step on every fclk cycle.

Parameters:
- DB_CNT, 20000: cycles a synchronised level must stay stable before it is accepted.
- REPEAT_DELAY, 500000: cycles from the first pulse to the first auto-repeat pulse.
- REPEAT_PERIOD, 100000: cycles between subsequent auto-repeat pulses.
- BTN_ACTIVE_LOW, 0: when 1, raw buttons are inverted at input.
- CNT_W, 20: counter width. Must hold max(DB_CNT, REPEAT_DELAY, REPEAT_PERIOD)-1.

Ports:
- fclk, input, 1: system clock. Single clock domain.
- rst, input, 1: reset, synchronous, active-low. Acts on the rising edge of fclk when rst=0.
- btn, input, 12: raw buttons, asynchronous. Bit map: [11] Forward, [10] Back, [9] Left, [8] Right, [7] Up, [6] Down, [5] rotX+, [4] rotX-, [3] rotY+, [2] rotY-, [1] rotZ+, [0] rotZ-.
- controlPad, output, 12: registered. Fields {FB, LR, UD, rotXpn, rotYpn, rotZpn}, 2 bits each, MSB first. Per pair: 10 = first button, 01 = second button, 00 = no step.
- pad_active, output, 1: registered. 1 while any axis channel is outside IDLE.

Behaviour:
- Reset (rst=0 at an fclk edge):
  - sync flops, debounced levels and all counters clear to 0.
  - All axis FSMs go to IDLE.
  - controlPad = 12'h000, pad_active = 0.
  - Reset wins over every other event in the same cycle.
- Input path:
  - Optional inversion, then a 2-flop synchroniser per bit.
- Debounce, per bit:
  - Holds a stable level and a counter.
  - If the sync value equals the stable level, the counter clears.
  - Otherwise the counter increments. On the cycle it equals DB_CNT-1, the stable level takes the sync value and the counter clears.
  - Any disagreement shorter than DB_CNT cycles is discarded.
- Pair decode, per axis, from the stable pair:
  - 10 gives dir = code 10.
  - 01 gives dir = code 01.
  - 00 or 11 gives dir = NONE. Both pressed means no motion.
- Axis FSM, 6 independent instances, with one shared counter per instance:
  - IDLE: if dir != NONE, emit dir, clear the counter, go to DELAY.
  - DELAY:
    - dir == NONE: go to IDLE, no emit.
    - dir differs from the last emitted code: emit the new dir, clear the counter, stay in DELAY.
    - Counter == REPEAT_DELAY-1: emit dir, clear the counter, go to REPEAT.
    - Otherwise: increment the counter.
  - REPEAT:
    - dir == NONE: go to IDLE.
    - dir changed: emit the new dir, clear the counter, go to DELAY.
    - Counter == REPEAT_PERIOD-1: emit dir, clear the counter.
    - Otherwise: increment the counter.
- Output:
  - controlPad pair = emitted code on an emit cycle, 00 otherwise. Each pulse is exactly one cycle wide.
  - Several axes may pulse in the same cycle.
- Latency:
  - Count from the first fclk edge at which btn is sampled high.
  - The first pulse is visible on controlPad after that edge plus 2 (sync) + DB_CNT (debounce) + 1 (output register) edges. This is 7 edges with DB_CNT = 4.
  - Release latency to IDLE is the same path. No pulse is emitted on release.
- Counters are unsigned and saturate-free. They are always cleared before reaching the terminal value + 1, so wrap-around is impossible.

Decomposition:
- Shared package:
  - Pair code constants: CODE_NONE = 2'b00, CODE_POS = 2'b10, CODE_NEG = 2'b01.
  - FSM state encoding: IDLE, DELAY, REPEAT (2 bits).
  - controlPad field bit indices.
- One sub-module: pad_axis_channel.
  - Holds 2-bit sync, debounce and FSM for one button pair.
  - Has the same parameters.
  - Outputs a 2-bit pulse and an active flag.
  - Instantiated 6 times in the top, which only registers and concatenates.

Test Plan:
Bench parameters: DB_CNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, BTN_ACTIVE_LOW=0.
1. Reset: hold rst=0 for 3 cycles with btn=12'hFFF -> controlPad=12'h000, pad_active=0 throughout.
2. Press-and-hold: btn[11]=1 from cycle 0, held for 30 cycles -> controlPad=12'h800 for one cycle at edge 7, 17, 20, 23, 26 ..., and 12'h000 between; pad_active=1 from edge 7.
3. Bounce: btn[9] high for 3 cycles, low for 2, high for 3, then low -> controlPad stays 12'h000 and pad_active stays 0.
4. Conflict: btn[5] and btn[4] both high from cycle 0 -> no pulse. At cycle 20, drop btn[4] -> single 12'h020 pulse 7 edges later, then repeat timing as in scenario 2.
5. Simultaneous axes: btn[8] and btn[2] rise in the same cycle -> one pulse 12'h104 at edge 7. Release both -> no further pulses; pad_active=0 after the release latency.
6. Reset mid-repeat: during REPEAT of btn[1], assert rst=0 for 1 cycle with btn held -> controlPad=0 and pad_active=0 next edge. After rst returns to 1, a fresh 12'h002 pulse appears 7 edges later.

Source files
------------

// File: rtl/control_pad_encoder_pkg.sv
// Shared constants, types and helpers for the control pad encoder.
// Pair codes, axis FSM encoding and controlPad field positions.
package control_pad_encoder_pkg;

    localparam int unsigned PAIR_W   = 2;
    localparam int unsigned NUM_AXES = 6;
    localparam int unsigned PAD_W    = PAIR_W * NUM_AXES;

    localparam logic [PAIR_W-1:0] CODE_NONE = 2'b00;
    localparam logic [PAIR_W-1:0] CODE_POS  = 2'b10;
    localparam logic [PAIR_W-1:0] CODE_NEG  = 2'b01;

    // LSB of each controlPad field; channel k drives bits [2k+1:2k]
    localparam int unsigned FIELD_FB_LSB   = 10;
    localparam int unsigned FIELD_LR_LSB   = 8;
    localparam int unsigned FIELD_UD_LSB   = 6;
    localparam int unsigned FIELD_ROTX_LSB = 4;
    localparam int unsigned FIELD_ROTY_LSB = 2;
    localparam int unsigned FIELD_ROTZ_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } axis_state_e;

    // Both or neither button pressed means no motion
    function automatic logic [PAIR_W-1:0] decode_pair(input logic [PAIR_W-1:0] pair);
        logic [PAIR_W-1:0] dir;
        dir = CODE_NONE;
        case (pair)
            2'b10:   dir = CODE_POS;
            2'b01:   dir = CODE_NEG;
            default: dir = CODE_NONE;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/control_pad_encoder_axis_channel.sv
// One button pair: synchroniser, debounce, pair decode and press/repeat FSM.
// Emits a registered one-cycle pulse carrying the pair code.
module pad_axis_channel
    import control_pad_encoder_pkg::*;
#(
    parameter int unsigned DB_CNT         = 20000,
    parameter int unsigned REPEAT_DELAY   = 500000,
    parameter int unsigned REPEAT_PERIOD  = 100000,
    parameter bit          BTN_ACTIVE_LOW = 1'b0,
    parameter int unsigned CNT_W          = 20
) (
    input  logic              fclk,
    input  logic              rst,
    input  logic [PAIR_W-1:0] btn_pair,
    output logic [PAIR_W-1:0] pulse,
    output logic              active
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CNT - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [PAIR_W-1:0] sync1, sync2, stable;
    logic [CNT_W-1:0]  db_cnt [PAIR_W];

    axis_state_e       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PAIR_W-1:0] last, last_nxt;
    logic [PAIR_W-1:0] emit_c;
    logic [PAIR_W-1:0] dir_c;

    // Input conditioning: inversion, 2-flop sync, per-bit debounce
    always_ff @(posedge fclk) begin
        if (!rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < int'(PAIR_W); i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_pair ^ {PAIR_W{BTN_ACTIVE_LOW}};
            sync2 <= sync1;
            for (int i = 0; i < int'(PAIR_W); i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign dir_c = decode_pair(stable);

    always_ff @(posedge fclk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            last   <= CODE_NONE;
            pulse  <= CODE_NONE;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            last   <= last_nxt;
            pulse  <= emit_c;
            active <= (state_nxt != ST_IDLE);
        end
    end

    // Next-state: first press, hold delay, then periodic repeat
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        emit_c    = CODE_NONE;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (dir_c != CODE_NONE) begin
                    emit_c    = dir_c;
                    last_nxt  = dir_c;
                    state_nxt = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (dir_c == CODE_NONE) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (dir_c != last) begin
                    emit_c   = dir_c;
                    last_nxt = dir_c;
                    cnt_nxt  = '0;
                end else if (cnt == RD_LAST) begin
                    emit_c    = dir_c;
                    cnt_nxt   = '0;
                    state_nxt = ST_REPEAT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (dir_c == CODE_NONE) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (dir_c != last) begin
                    emit_c    = dir_c;
                    last_nxt  = dir_c;
                    cnt_nxt   = '0;
                    state_nxt = ST_DELAY;
                end else if (cnt == RP_LAST) begin
                    emit_c  = dir_c;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/control_pad_encoder.sv
// Button-to-controlPad encoder: six independent axis channels whose pulses
// are registered and concatenated into the 12-bit step bus.
module control_pad_encoder
    import control_pad_encoder_pkg::*;
#(
    parameter int unsigned DB_CNT         = 20000,
    parameter int unsigned REPEAT_DELAY   = 500000,
    parameter int unsigned REPEAT_PERIOD  = 100000,
    parameter bit          BTN_ACTIVE_LOW = 1'b0,
    parameter int unsigned CNT_W          = 20
) (
    input  logic             fclk,
    input  logic             rst,
    input  logic [PAD_W-1:0] btn,
    output logic [PAD_W-1:0] controlPad,
    output logic             pad_active
);

    logic [PAD_W-1:0]    pulse_all;
    logic [NUM_AXES-1:0] active_all;

    // Channel k owns btn/controlPad bits [2k+1:2k]
    for (genvar k = 0; k < int'(NUM_AXES); k++) begin : g_axis
        pad_axis_channel #(
            .DB_CNT        (DB_CNT),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW),
            .CNT_W         (CNT_W)
        ) u_ch (
            .fclk    (fclk),
            .rst     (rst),
            .btn_pair(btn[PAIR_W*k +: PAIR_W]),
            .pulse   (pulse_all[PAIR_W*k +: PAIR_W]),
            .active  (active_all[k])
        );
    end

    always_ff @(posedge fclk) begin
        if (!rst) begin
            controlPad <= '0;
            pad_active <= 1'b0;
        end else begin
            controlPad <= pulse_all;
            pad_active <= |active_all;
        end
    end

endmodule

// File: tb/tb_control_pad_encoder.sv
// Directed bench for control_pad_encoder with short debounce/repeat timing.
module tb_control_pad_encoder;

    logic        fclk = 1'b0;
    logic        rst;
    logic [11:0] btn;
    logic [11:0] controlPad;
    logic        pad_active;

    int total = 0;
    int bad   = 0;

    always #5 fclk = ~fclk;

    control_pad_encoder #(
        .DB_CNT        (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3),
        .BTN_ACTIVE_LOW(1'b0),
        .CNT_W         (20)
    ) dut (
        .fclk      (fclk),
        .rst       (rst),
        .btn       (btn),
        .controlPad(controlPad),
        .pad_active(pad_active)
    );

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        btn = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic check_edge(input string sc, input int e, input logic [11:0] exp_pad,
                              input logic exp_act);
        check($sformatf("%s_pad_e%0d", sc, e), controlPad, exp_pad);
        check($sformatf("%s_act_e%0d", sc, e), {11'b0, pad_active}, {11'b0, exp_act});
    endtask

    initial begin
        logic [11:0] ep;
        logic        ea;
        rst = 1'b0;
        btn = 12'hFFF;

        // 1: reset holds outputs low even with every button pressed
        for (int c = 0; c < 3; c++) begin
            tick();
            check_edge("rst", c, 12'h000, 1'b0);
        end
        do_reset();

        // 2: press-and-hold Forward for 30 cycles
        for (int e = 0; e <= 45; e++) begin
            btn = (e < 30) ? 12'h800 : 12'h000;
            tick();
            ep = (e == 7 || (e >= 17 && e <= 35 && (e - 17) % 3 == 0)) ? 12'h800 : 12'h000;
            ea = (e >= 7 && e <= 36);
            check_edge("hold", e, ep, ea);
        end
        do_reset();

        // 3: bounces shorter than the debounce window are ignored
        for (int e = 0; e <= 24; e++) begin
            btn = ((e <= 2) || (e >= 5 && e <= 7)) ? 12'h200 : 12'h000;
            tick();
            check_edge("bounce", e, 12'h000, 1'b0);
        end
        do_reset();

        // 4: rotX+/rotX- conflict, then rotX- released at cycle 20
        for (int e = 0; e <= 45; e++) begin
            btn = (e < 20) ? 12'h030 : 12'h020;
            tick();
            ep = (e == 27 || (e >= 37 && (e - 37) % 3 == 0)) ? 12'h020 : 12'h000;
            ea = (e >= 27);
            check_edge("conflict", e, ep, ea);
        end
        do_reset();

        // 5: Right and rotY- together, released before the repeat delay
        for (int e = 0; e <= 25; e++) begin
            btn = (e <= 5) ? 12'h104 : 12'h000;
            tick();
            ep = (e == 7) ? 12'h104 : 12'h000;
            ea = (e >= 7 && e <= 12);
            check_edge("simul", e, ep, ea);
        end
        do_reset();

        // 6: one-cycle reset during rotZ+ repeat, button kept held
        for (int e = 0; e <= 40; e++) begin
            btn = 12'h002;
            rst = (e == 24) ? 1'b0 : 1'b1;
            tick();
            if (e < 24) begin
                ep = (e == 7 || e == 17 || e == 20 || e == 23) ? 12'h002 : 12'h000;
                ea = (e >= 7);
            end else if (e == 24) begin
                ep = 12'h000;
                ea = 1'b0;
            end else begin
                ep = (e == 32) ? 12'h002 : 12'h000;
                ea = (e >= 32);
            end
            check_edge("midrst", e, ep, ea);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
